mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequencer and arbiter that owns the byte-wide RAM/IO port and shares it between the instruction-cache miss path and the load/store buffer.
- Accepts whole-word and partial requests, serialises them into byte accesses, and assembles or sign-extends read data.
- Handles IO-buffer back-pressure, flush and CPU pause (rdy_in).
- Sits between icache/LSB and the top-level mem_* pins.

Parameters:
- ADDR_WIDTH, 32, byte address width
- LSB_ID_WIDTH, 3, load tag width returned with load data
- MAX_LSB_STREAK, 4, consecutive LSB grants allowed while a fetch is pending

Ports:
- clk  in  1  clock, rising edge
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  0 = freeze all state; mem_rw forced 0
- flush  in  1  misprediction flush, synchronous
- io_buffer_full  in  1  UART buffer full
- mem_din  in  8  RAM read byte, valid the cycle after its address
- mem_aout  out  ADDR_WIDTH  RAM byte address
- mem_dout  out  8  RAM write byte
- mem_rw  out  1  1 = write
- if_req  in  1  fetch request; held until if_done
- if_pc  in  ADDR_WIDTH  fetch address
- if_done  out  1  one-cycle pulse, fetch complete
- if_inst  out  32  fetched word, valid with if_done
- lsb_req  in  1  LSB request; held until lsb_done
- lsb_we  in  1  1 = store
- lsb_addr  in  ADDR_WIDTH  access address
- lsb_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- lsb_wdata  in  32  store data
- lsb_id  in  LSB_ID_WIDTH  load tag
- lsb_done  out  1  one-cycle pulse, load or store complete
- lsb_rdata  out  32  extended load value, valid with lsb_done
- lsb_rid  out  LSB_ID_WIDTH  tag of the completed load
- busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- Reset (async, rst_n_in=0):
  - State IDLE; all outputs 0; byte counter 0; streak counter 0.
- States: IDLE, ISSUE, CAPTURE, IO_WAIT.
- IDLE, arbitration:
  - lsb_req wins over if_req, except: if_req high and streak == MAX_LSB_STREAK -> grant fetch.
  - Streak increments on an LSB grant while if_req is high; clears on a fetch grant or when if_req is low.
  - On grant, latch addr, we, len, wdata, funct3 and id; go to ISSUE.
  - len = 1/2/4 for funct3[1:0] = 00/01/10; fetch len = 4, we = 0.
  - No bus activity in IDLE: mem_aout=0, mem_rw=0.
- ISSUE, cycle k = 0..len-1:
  - mem_aout = base+k (ADDR_WIDTH wraps modulo 2^ADDR_WIDTH).
  - mem_rw = we; mem_dout = wdata byte k.
  - Reads capture mem_din into byte k-1 when k >= 1.
  - After k = len-1: reads go to CAPTURE; writes return to IDLE and pulse lsb_done the next cycle.
- CAPTURE:
  - Capture last byte; mem_rw=0; go to IDLE.
  - Register done, so if_done/lsb_done assert the following cycle.
- Latency, counting the accept cycle as 0: read done visible at cycle len+2; write done at cycle len+1.
- Load extension:
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through.
  - Bytes are assembled little-endian.
- IO stall:
  - Condition: in ISSUE with we=1, addr[17:16]==2'b11 and io_buffer_full=1.
  - Enter IO_WAIT with mem_rw=0 and the counter held.
  - Resume ISSUE at the same k when io_buffer_full drops.
- rdy_in=0: all registers hold; outputs except mem_rw keep their values; a pending done pulse is deferred, not lost.
- flush:
  - Aborts fetches and non-IO loads at once: return to IDLE, no done pulse, pending done cleared.
  - Stores and IO-region loads run to completion and still pulse done.
  - flush in IDLE blocks any grant that cycle.
- Requests: requesters must hold req and fields stable until done; a new grant is possible in the cycle done is visible.
- Outputs: if_inst/lsb_rdata are 0 when their done is low; only one done fires per cycle.

Test Plan:
- Fetch, if_pc=0x100, RAM bytes 13 05 00 00 -> if_done at cycle 6, if_inst=0x00000513, addresses 0x100..0x103 issued.
- LB at 0x200 holding 0x80 -> lsb_rdata=0xFFFFFF80; LBU -> 0x00000080; LH at bytes 0x34 0x92 -> 0xFFFF9234.
- SW 0xDEADBEEF to 0x10 -> writes EF, BE, AD, DE to 0x10..0x13 with mem_rw=1; lsb_done at cycle 5.
- SB to 0x30000 with io_buffer_full high 3 cycles -> mem_rw stays 0 for 3 cycles, then one write, then done.
- if_req and lsb_req held continuously -> after 4 LSB grants, 1 fetch grant; repeating pattern.
- flush during fetch byte 2 -> no if_done, busy=0 next cycle; flush during SW -> all 4 bytes still written, lsb_done pulses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - RAM port, fetch and load/store request bundle for mem_arbiter
//
// Purpose: groups the byte-wide RAM pins and the two requester handshakes
//          (icache miss path, load/store buffer) into one bundle.
// Ports (slave = arbiter side):
//   mem_din/mem_aout/mem_dout/mem_rw : byte-wide RAM/IO port
//   if_req/if_pc -> if_done/if_inst  : instruction fetch, whole word
//   lsb_req/lsb_we/lsb_addr/lsb_funct3/lsb_wdata/lsb_id
//     -> lsb_done/lsb_rdata/lsb_rid  : load/store, byte/half/word
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LSB_ID_WIDTH = 3
);
  logic [7:0]              mem_din;
  logic [ADDR_WIDTH-1:0]   mem_aout;
  logic [7:0]              mem_dout;
  logic                    mem_rw;

  logic                    if_req;
  logic [ADDR_WIDTH-1:0]   if_pc;
  logic                    if_done;
  logic [31:0]             if_inst;

  logic                    lsb_req;
  logic                    lsb_we;
  logic [ADDR_WIDTH-1:0]   lsb_addr;
  logic [2:0]              lsb_funct3;
  logic [31:0]             lsb_wdata;
  logic [LSB_ID_WIDTH-1:0] lsb_id;
  logic                    lsb_done;
  logic [31:0]             lsb_rdata;
  logic [LSB_ID_WIDTH-1:0] lsb_rid;

  modport slave (
    input  mem_din,
    output mem_aout, mem_dout, mem_rw,
    input  if_req, if_pc,
    output if_done, if_inst,
    input  lsb_req, lsb_we, lsb_addr, lsb_funct3, lsb_wdata, lsb_id,
    output lsb_done, lsb_rdata, lsb_rid
  );

  modport master (
    output mem_din,
    input  mem_aout, mem_dout, mem_rw,
    output if_req, if_pc,
    input  if_done, if_inst,
    output lsb_req, lsb_we, lsb_addr, lsb_funct3, lsb_wdata, lsb_id,
    input  lsb_done, lsb_rdata, lsb_rid
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM/IO sequencer shared by fetch and load/store paths
//
// Purpose: arbitrates between instruction fetch and the load/store buffer,
//          splits each request into byte accesses on the RAM port, assembles
//          little-endian read data and sign/zero-extends loads.
// Ports:
//   clk            : clock, rising edge
//   rst_n_in       : asynchronous active-low reset
//   rdy_in         : 0 freezes all state and forces mem_rw low
//   flush          : misprediction flush (aborts fetches and non-IO loads)
//   io_buffer_full : IO buffer back-pressure for stores to the IO region
//   busy           : a transaction is in flight
//   bus            : RAM pins plus fetch and load/store handshakes
module mem_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LSB_ID_WIDTH   = 3,
  parameter int MAX_LSB_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst_n_in,
  input  logic         rdy_in,
  input  logic         flush,
  input  logic         io_buffer_full,
  output logic         busy,
  mem_arbiter_if.slave bus
);

  localparam int SW = (MAX_LSB_STREAK < 1) ? 1 : $clog2(MAX_LSB_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSB_STREAK);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_IO_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;          // byte index within the access
  logic [1:0]              lastk_q, lastk_d;  // len-1
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [LSB_ID_WIDTH-1:0] id_q, id_d;
  logic                    fetch_q, fetch_d;
  logic [31:0]             buf_q, buf_d;      // bytes captured so far
  logic [SW-1:0]           streak_q, streak_d;
  logic                    done_if_q, done_if_d;
  logic                    done_lsb_q, done_lsb_d;
  logic [31:0]             rdata_q, rdata_d;

  logic        io_region;
  logic        io_stall;
  logic        abortable;
  logic        grant_if;
  logic        grant_lsb;
  logic [31:0] word;
  logic [31:0] ext;

  assign io_region = (addr_q[17:16] == 2'b11);
  assign io_stall  = (state_q == S_ISSUE) && we_q && io_region && io_buffer_full;
  // Stores and IO loads have side effects, so only fetches and RAM loads may be dropped.
  assign abortable = fetch_q || (!we_q && !io_region);

  assign grant_if  = (state_q == S_IDLE) && !flush && bus.if_req &&
                     (!bus.lsb_req || (streak_q == STREAK_MAX));
  assign grant_lsb = (state_q == S_IDLE) && !flush && bus.lsb_req && !grant_if;

  // Final byte arrives on mem_din during CAPTURE; merge it before extending.
  always_comb begin
    word = buf_q;
    word[{lastk_q, 3'b000} +: 8] = bus.mem_din;
  end

  always_comb begin
    case (funct3_q)
      3'b000:  ext = {{24{word[7]}}, word[7:0]};
      3'b001:  ext = {{16{word[15]}}, word[15:0]};
      3'b100:  ext = {24'h0, word[7:0]};
      3'b101:  ext = {16'h0, word[15:0]};
      default: ext = word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    lastk_d    = lastk_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    id_d       = id_q;
    fetch_d    = fetch_q;
    buf_d      = buf_q;
    rdata_d    = rdata_q;
    done_if_d  = 1'b0;
    done_lsb_d = 1'b0;
    streak_d   = streak_q;

    if (!bus.if_req || grant_if) begin
      streak_d = '0;
    end else if (grant_lsb && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + SW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (grant_if) begin
          state_d  = S_ISSUE;
          k_d      = 2'd0;
          lastk_d  = 2'd3;
          addr_d   = bus.if_pc;
          we_d     = 1'b0;
          wdata_d  = 32'h0;
          funct3_d = 3'b010;
          fetch_d  = 1'b1;
        end else if (grant_lsb) begin
          state_d  = S_ISSUE;
          k_d      = 2'd0;
          case (bus.lsb_funct3[1:0])
            2'b00:   lastk_d = 2'd0;
            2'b01:   lastk_d = 2'd1;
            default: lastk_d = 2'd3;
          endcase
          addr_d   = bus.lsb_addr;
          we_d     = bus.lsb_we;
          wdata_d  = bus.lsb_wdata;
          funct3_d = bus.lsb_funct3;
          id_d     = bus.lsb_id;
          fetch_d  = 1'b0;
        end
      end

      S_ISSUE: begin
        if (flush && abortable) begin
          state_d = S_IDLE;
        end else if (io_stall) begin
          state_d = S_IO_WAIT;
        end else begin
          // mem_din now carries the byte addressed in the previous cycle.
          if (!we_q && (k_q != 2'd0)) begin
            buf_d[{k_q - 2'd1, 3'b000} +: 8] = bus.mem_din;
          end
          if (k_q == lastk_q) begin
            if (we_q) begin
              state_d    = S_IDLE;
              done_lsb_d = 1'b1;
              rdata_d    = 32'h0;
            end else begin
              state_d = S_CAPTURE;
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
      end

      S_CAPTURE: begin
        state_d = S_IDLE;
        if (!(flush && abortable)) begin
          rdata_d    = ext;
          done_if_d  = fetch_q;
          done_lsb_d = !fetch_q;
        end
      end

      S_IO_WAIT: begin
        if (!io_buffer_full) begin
          state_d = S_ISSUE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= S_IDLE;
      k_q        <= 2'd0;
      lastk_q    <= 2'd0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= 32'h0;
      funct3_q   <= 3'b000;
      id_q       <= '0;
      fetch_q    <= 1'b0;
      buf_q      <= 32'h0;
      streak_q   <= '0;
      done_if_q  <= 1'b0;
      done_lsb_q <= 1'b0;
      rdata_q    <= 32'h0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      k_q        <= k_d;
      lastk_q    <= lastk_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      funct3_q   <= funct3_d;
      id_q       <= id_d;
      fetch_q    <= fetch_d;
      buf_q      <= buf_d;
      streak_q   <= streak_d;
      done_if_q  <= done_if_d;
      done_lsb_q <= done_lsb_d;
      rdata_q    <= rdata_d;
    end
  end

  logic on_bus;
  assign on_bus = (state_q == S_ISSUE) || (state_q == S_IO_WAIT);

  assign bus.mem_aout  = on_bus ? (addr_q + ADDR_WIDTH'(k_q)) : '0;
  assign bus.mem_dout  = on_bus ? wdata_q[{k_q, 3'b000} +: 8] : 8'h0;
  assign bus.mem_rw    = rdy_in && (state_q == S_ISSUE) && we_q && !io_stall;

  assign bus.if_done   = done_if_q;
  assign bus.if_inst   = done_if_q ? rdata_q : 32'h0;
  assign bus.lsb_done  = done_lsb_q;
  assign bus.lsb_rdata = done_lsb_q ? rdata_q : 32'h0;
  assign bus.lsb_rid   = done_lsb_q ? id_q : '0;

  assign busy = (state_q != S_IDLE);

endmodule
